mmio_dmem: RTL

//  Data-memory stage consumed by the single-cycle MIPS core: replaces plain dmem on the core's

---
 rtl/mmio_pkg.sv | 15 +
 rtl/byte_fifo.sv | 44 ++++
 rtl/mmio_dmem.sv | 90 +++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared address-decode and status-layout definitions for the MMIO data-memory stage.
package mmio_pkg;
  localparam int MMIO_BASE = 31;

  typedef enum logic [1:0] {
    TXDATA = 2'b00,
    STATUS = 2'b01,
    CYCLE  = 2'b10,
    RSVD   = 2'b11
  } mmio_sel_e;

  localparam int OVF_BIT   = 9;
  localparam int FULL_BIT  = 8;
  localparam int COUNT_MSB = 7;
endpackage

// File: rtl/byte_fifo.sv
// Byte ring buffer with occupancy count; storage is unreset, so clearing count discards contents.
module byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow_evt
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty        = (count == '0);
  assign full         = (count == (AW+1)'(DEPTH));
  assign do_pop       = pop & ~empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
  assign do_push      = push & (~full | do_pop);
  assign overflow_evt = push & ~do_push;
  assign dout         = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push != do_pop)
        count <= do_push ? count + (AW+1)'(1) : count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/mmio_dmem.sv
// Core data memory: word RAM below 0x80000000, TX FIFO / status / cycle counter above.
module mmio_dmem
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int IW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [IW-1:0] idx;
  logic          mmio;
  mmio_sel_e     sel;
  logic          push, stat_wr, cyc_wr;
  logic [CW-1:0] count;
  logic          full, empty, ovf_evt, overflow;
  logic [31:0]   cycle, status;

  assign idx  = a[IW+1:2];
  assign mmio = a[MMIO_BASE];
  assign sel  = mmio_sel_e'(a[3:2]);

  // Upper RAM index bits alias; byte offset is ignored.
  logic unused_addr;
  assign unused_addr = &{1'b0, a[30:IW+2], a[1:0]};

  assign push    = we & mmio & (sel == TXDATA);
  assign stat_wr = we & mmio & (sel == STATUS);
  assign cyc_wr  = we & mmio & (sel == CYCLE);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .din          (wd[7:0]),
    .pop          (tx_valid & tx_ready),
    .dout         (tx_data),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow_evt (ovf_evt)
  );

  assign tx_valid = ~empty;

  always_ff @(posedge clk)
    if (we && !mmio) ram[idx] <= wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle    <= '0;
      overflow <= 1'b0;
    end else begin
      cycle <= cyc_wr ? wd : cycle + 32'd1;
      // A dropped byte on the clearing edge must not be lost from the sticky flag.
      if (ovf_evt)      overflow <= 1'b1;
      else if (stat_wr) overflow <= 1'b0;
    end
  end

  always_comb begin
    status                = '0;
    status[OVF_BIT]       = overflow;
    status[FULL_BIT]      = full;
    status[COUNT_MSB:0]   = 8'(count);
  end

  always_comb begin
    rd = '0;
    if (!mmio) rd = ram[idx];
    else begin
      case (sel)
        STATUS:  rd = status;
        CYCLE:   rd = cycle;
        default: rd = '0;
      endcase
    end
  end
endmodule
